// File: rtl/mem_copy_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_engine_if
// Brief    : Command and memory-bus bundle for the copy/fill engine.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_copy_engine_if #(
  parameter int W = 32,
  parameter int A = 12
);
  logic         start;
  logic         mode;
  logic [A-1:0] src_addr;
  logic [A-1:0] dst_addr;
  logic [A:0]   len;
  logic [W-1:0] fill_data;
  logic         busy;
  logic         done;
  logic [A-1:0] mem_addr;
  logic         mem_write;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  // Engine side
  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_data, mem_rdata,
    output busy, done, mem_addr, mem_write, mem_wdata
  );

  // Controller / memory side
  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_data, mem_rdata,
    input  busy, done, mem_addr, mem_write, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_engine
// Brief    : Word-at-a-time copy / fill initiator for a single-port memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
  parameter int W = 32,
  parameter int A = 12
) (
  input  logic               clk,
  input  logic               rst,
  mem_copy_engine_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       state;
  logic         mode_r;
  logic [A-1:0] src_r;
  logic [A-1:0] dst_r;
  logic [A:0]   len_r;
  logic [A:0]   idx;
  logic         busy_r;
  logic         done_r;
  logic         mem_write_r;
  logic [A-1:0] mem_addr_r;
  logic [W-1:0] mem_wdata_r;

  logic [A:0]   idx_next;
  logic [A-1:0] src_next_addr;
  logic [A-1:0] dst_cur_addr;
  logic [A-1:0] dst_next_addr;
  logic         last_word;

  // Address sums truncate to A bits so walks wrap past the top of memory.
  assign idx_next      = idx + 1'b1;
  assign src_next_addr = src_r + idx_next[A-1:0];
  assign dst_cur_addr  = dst_r + idx[A-1:0];
  assign dst_next_addr = dst_r + idx_next[A-1:0];
  assign last_word     = (idx == (len_r - 1'b1));

  // Memory-facing outputs are all flops, so they are stable for the whole cycle.
  // mem_wdata_r doubles as the copy buffer: READ captures straight into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      idx         <= '0;
      mode_r      <= 1'b0;
      src_r       <= '0;
      dst_r       <= '0;
      len_r       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          mem_write_r <= 1'b0;
          if (bus.start) begin
            mode_r <= bus.mode;
            src_r  <= bus.src_addr;
            dst_r  <= bus.dst_addr;
            len_r  <= bus.len;
            idx    <= '0;
            busy_r <= 1'b1;
            if (bus.len == '0) begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end else if (bus.mode) begin
              state       <= S_WRITE;
              mem_addr_r  <= bus.dst_addr;
              mem_write_r <= 1'b1;
              mem_wdata_r <= bus.fill_data;
            end else begin
              state      <= S_READ;
              mem_addr_r <= bus.src_addr;
            end
          end
        end

        S_READ: begin
          mem_wdata_r <= bus.mem_rdata;
          mem_addr_r  <= dst_cur_addr;
          mem_write_r <= 1'b1;
          state       <= S_WRITE;
        end

        S_WRITE: begin
          idx <= idx_next;
          if (last_word) begin
            state       <= S_DONE;
            mem_write_r <= 1'b0;
            done_r      <= 1'b1;
          end else if (mode_r) begin
            mem_addr_r <= dst_next_addr;
          end else begin
            state       <= S_READ;
            mem_write_r <= 1'b0;
            mem_addr_r  <= src_next_addr;
          end
        end

        S_DONE: begin
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          mem_write_r <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_write = mem_write_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule
`default_nettype wire
